// File: rtl/shift_unit_iterative.sv
// Iterative multi-mode shifter: SLL/SRL/SRA/ROR, STEP bit positions per clock,
// with valid/ready handshakes on the request and result sides.
module shift_unit_iterative #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_amount,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH-1:0] W_AMT    = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    W_CNT    = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_CNT = CW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    state_e           state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [CW-1:0]    step_amt;
    logic [CW-1:0]    eff_amt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_zero_q;
    logic [WIDTH-1:0] out_data_q;

    // Over-range amounts saturate to WIDTH so the iteration count stays bounded.
    always_comb begin
        eff_amt = '0;
        if (mode_e'(in_mode) == MODE_ROR) begin
            eff_amt = {1'b0, in_amount[AW-1:0]};
        end else if (in_amount >= W_AMT) begin
            eff_amt = W_CNT;
        end else begin
            eff_amt = in_amount[CW-1:0];
        end
    end

    always_comb begin
        step_amt = (rem_q < STEP_CNT) ? rem_q : STEP_CNT;
        rem_d    = rem_q - step_amt;
        work_d   = work_q;
        case (mode_q)
            MODE_SLL: work_d = work_q << step_amt;
            MODE_SRL: work_d = work_q >> step_amt;
            MODE_SRA: work_d = $unsigned($signed(work_q) >>> step_amt);
            MODE_ROR: work_d = (work_q >> step_amt) | (work_q << (W_CNT - step_amt));
            default:  work_d = work_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_SLL;
            work_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_data;
                        mode_q     <= mode_e'(in_mode);
                        rem_q      <= eff_amt;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= work_q;
                        out_zero_q  <= (work_q == '0);
                        state_q     <= DONE;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_unit_iterative.sv
// Directed-vector bench for shift_unit_iterative: a STEP=4 and a STEP=1 instance
// share clock and reset; index 0 is the STEP=4 unit, index 1 the STEP=1 unit.
module tb_shift_unit_iterative;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [31:0] in_amount [2];
    logic [1:0]  in_mode   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        out_zero  [2];

    int checks   = 0;
    int failures = 0;

    shift_unit_iterative #(.WIDTH(32), .STEP(4)) u_dut_s4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_amount (in_amount[0]),
        .in_mode   (in_mode[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .out_zero  (out_zero[0])
    );

    shift_unit_iterative #(.WIDTH(32), .STEP(1)) u_dut_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_amount (in_amount[1]),
        .in_mode   (in_mode[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .out_zero  (out_zero[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it through to consumption.
    task automatic run(input int idx, input logic [1:0] mode, input logic [31:0] data,
                       input logic [31:0] amt, input logic [31:0] exp_data,
                       input logic exp_zero, input int exp_lat, input bit hold_valid,
                       input int bp_cycles, input string tag);
        int lat;
        int low_cnt;
        bit stable;
        lat     = 0;
        low_cnt = 0;
        stable  = 1'b1;
        @(negedge clk);
        check({tag, ".ready_idle"}, 64'(in_ready[idx]), 64'd1);
        out_ready[idx] = (bp_cycles == 0);
        in_valid[idx]  = 1'b1;
        in_data[idx]   = data;
        in_amount[idx] = amt;
        in_mode[idx]   = mode;
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid[idx] = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!in_ready[idx]) low_cnt++;
            if (out_valid[idx]) break;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".data"}, 64'(out_data[idx]), 64'(exp_data));
        check({tag, ".zero"}, 64'(out_zero[idx]), 64'(exp_zero));
        check({tag, ".ready_low"}, 64'(low_cnt), 64'(exp_lat));
        for (int c = 0; c < bp_cycles; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid[idx] || out_data[idx] !== exp_data || in_ready[idx]) stable = 1'b0;
        end
        if (bp_cycles > 0) begin
            check({tag, ".bp_stable"}, 64'(stable), 64'd1);
            @(negedge clk);
            out_ready[idx] = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        check({tag, ".back_idle"}, {62'd0, in_ready[idx], out_valid[idx]}, 64'd2);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_amount[i] = '0;
            in_mode[i]   = '0;
            out_ready[i] = 1'b1;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            check("reset.in_ready", 64'(in_ready[i]), 64'd1);
            check("reset.out_valid", 64'(out_valid[i]), 64'd0);
            check("reset.out_data", 64'(out_data[i]), 64'd0);
            check("reset.out_zero", 64'(out_zero[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // STEP=4 unit
        run(0, SRA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 2, 1'b0, 0, "sra_msb_4");
        run(0, SRA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 9, 1'b0, 0, "sra_ones_big");
        run(0, SRL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 9, 1'b0, 0, "srl_ones_big");
        run(0, ROR, 32'h12345678, 32'd36,       32'h81234567, 1'b0, 2, 1'b0, 0, "ror_36");
        run(0, SLL, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 9, 1'b0, 0, "sll_31");
        run(0, SRA, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 1, 1'b0, 0, "sra_0");
        run(0, SLL, 32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 1'b0, 1, 1'b0, 0, "sll_0");
        run(0, ROR, 32'hA5A5A5A5, 32'd32,       32'hA5A5A5A5, 1'b0, 1, 1'b0, 0, "ror_32");
        run(0, SLL, 32'hFFFFFFFF, 32'd32,       32'h00000000, 1'b1, 9, 1'b0, 0, "sll_32");
        run(0, SRA, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 9, 1'b0, 0, "sra_pos_msbamt");
        run(0, ROR, 32'h0000000F, 32'd3,        32'hE0000001, 1'b0, 2, 1'b0, 0, "ror_3_partial");
        run(0, SRL, 32'h80000000, 32'd6,        32'h02000000, 1'b0, 3, 1'b0, 0, "srl_6");

        // STEP=1 unit
        run(1, SRL, 32'h0000F000, 32'd12,       32'h0000000F, 1'b0, 13, 1'b1, 0, "s1_srl_hold");
        run(1, ROR, 32'h000000FF, 32'd8,        32'hFF000000, 1'b0, 9,  1'b0, 5, "s1_ror_bp");
        run(1, SRA, 32'h80000000, 32'd3,        32'hF0000000, 1'b0, 4,  1'b0, 0, "s1_sra_3");

        // Reset in the middle of a STEP=1 shift
        @(negedge clk);
        in_valid[1]  = 1'b1;
        in_data[1]   = 32'h12345678;
        in_amount[1] = 32'd20;
        in_mode[1]   = SRL;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst.in_ready", 64'(in_ready[1]), 64'd1);
        check("midrst.out_valid", 64'(out_valid[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (out_valid[1]) saw_valid = 1'b1;
            end
            check("midrst.no_pulse", 64'(saw_valid), 64'd0);
        end
        run(1, SLL, 32'h000000A5, 32'd8, 32'h0000A500, 1'b0, 9, 1'b0, 0, "post_rst_sll");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit_iterative.md
Name: shift_unit_iterative

Overview:
- Multi-mode, width-parametrised, multi-cycle shifter for the ALU datapath.
- Performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand using an unsigned WIDTH-bit shift amount.
- Shifts STEP bit positions per clock, trading latency for area against the combinational shifters.
- Valid/ready handshakes on both sides; sits between the ALU operand registers and the result writeback.

Parameters:
- WIDTH, 32, operand, result and shift-amount width; a power of 2, at least 8.
- STEP, 1, bit positions shifted per cycle; a power of 2, 1 to WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- in_data  input  WIDTH  operand.
- in_amount  input  WIDTH  unsigned shift amount.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_zero  output  1  result is all zeros; valid with out_valid.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=0; working register and counter cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid, in_data, mode and effective amount are latched, then go to SHIFT.
  - SHIFT: each cycle the working register shifts by min(STEP, remaining) and remaining decreases by the same value. When remaining is 0 at a clock edge, go to DONE; the register is not shifted that cycle.
  - DONE: out_valid=1. out_data and out_zero are stable until out_ready. out_valid && out_ready returns to IDLE.
- Effective amount:
  - SLL, SRL, SRA: min(in_amount, WIDTH). Any amount of WIDTH or more, including amounts with the MSB set, gives 0 for SLL/SRL and all copies of the operand sign bit for SRA.
  - ROR: in_amount mod WIDTH.
- Counter width: clog2(WIDTH)+1 bits.
- Fill bits: SLL and SRL fill with 0. SRA fills with the latched operand bit WIDTH-1. ROR wraps bit 0 into bit WIDTH-1.
- Latency: from the accepting edge to out_valid high is 1 + ceil(eff/STEP) cycles. Amount 0 gives 1 cycle, with out_data = in_data.
- No special case for an operand of all ones: SRA of all ones by any amount gives all ones.
- Throughput: one request in flight. in_ready is low in SHIFT and DONE. A new request cannot be accepted on the same cycle a result is consumed; it is accepted in IDLE the following cycle.
- in_valid in a non-IDLE state is ignored. The requester must hold it until in_ready.
- Backpressure: in DONE with out_ready=0, outputs hold indefinitely with no change.
- Reset mid-operation: asynchronous return to IDLE with the reset values. The in-flight request is discarded and no out_valid pulse follows.
- out_zero is registered from the final working register, not from the inputs.

Test Plan:
1. WIDTH=32, STEP=4: SRA 0x80000000 by 4 -> 0xF8000000, out_zero=0, out_valid 2 cycles after accept.
2. WIDTH=32, STEP=4: SRA 0xFFFFFFFF by 0xFFFFFFFF -> 0xFFFFFFFF; SRL 0xFFFFFFFF by 0xFFFFFFFF -> 0x00000000 with out_zero=1; both with latency 9.
3. ROR 0x12345678 by 36 -> 0x81234567 (effective amount 4). SLL 0x00000001 by 31 -> 0x80000000. Any mode by 0 -> operand unchanged, latency 1.
4. STEP=1, SRL 0x0000F000 by 12: in_valid held throughout SHIFT -> no second accept; in_ready low for 13 cycles; result 0x0000000F.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data and out_valid stable. Assert out_ready -> IDLE next cycle, in_ready=1.
6. Assert rst mid-SHIFT -> out_valid=0 and in_ready=1 immediately. A request accepted after reset returns its correct result with no stale data.
